uart_tx_cfg: RTL and testbench

Parametrised, second-generation UART transmitter. Serialises one word per frame with configurable data width, parity and stop bits, and uses a valid/ready input handshake. An optional transmit FIFO lets producers queue bursts. It sits between on-chip producers (debug and telemetry logic) and the board TX pin.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_fifo.sv | 71 +++++++
 rtl/uart_tx_cfg.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: serializer
// state encoding, parity mode constants and a frame-length helper.
package uart_pkg;

  // Serializer states; explicit encoding keeps waveforms readable.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Number of bit periods in one frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int data_bits, input int parity,
                                    input int stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock FIFO with registered full/empty flags and show-ahead read
// data. Buffers words ahead of the UART serializer when the FIFO build is
// selected. Reset is synchronous and active-high.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage write port.
  // NOTE: the array has no reset; flags and pointers alone define which
  // entries are valid, and a reset would turn the RAM into flops.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers, occupancy and registered flags; push+pop together keep count.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10: begin
          count <= count + 1'b1;
          full  <= (count == (AW + 1)'(DEPTH - 1));
          empty <= 1'b0;
        end
        2'b01: begin
          count <= count - 1'b1;
          full  <= 1'b0;
          empty <= (count == (AW + 1)'(1));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional parity, STOP_BITS stop bits, each DIVIDER clocks long, fed through
// a valid/ready handshake. Defining UART_TX_FIFO_EN inserts a FIFO_DEPTH-entry
// FIFO ahead of the serializer; otherwise words load straight into the shift
// register and o_ready follows the FSM.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int HZ         = 200_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int DIVIDER    = HZ / BAUDRATE,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_signal,
  output logic                 o_busy
);

  localparam int CNT_W = $clog2(DIVIDER);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIVIDER - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  if (DIVIDER < 2) begin : g_bad_divider
    $error("uart_tx_cfg: DIVIDER must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < PARITY_NONE || PARITY > PARITY_ODD) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  tx_state_t            state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 line;

  logic [DATA_BITS-1:0] word;
  logic                 word_avail;
  logic                 queued;
  logic                 bit_end;
  logic                 stop_end;
  logic                 can_load;
  logic                 take;

  assign bit_end  = (bit_cnt == CNT_LAST);
  assign stop_end = (state == ST_STOP) && bit_end && (bit_idx == STOP_LAST);
  // The shift register is free when idle or in the final cycle of the frame,
  // which is what makes back-to-back frames gapless.
  assign can_load = (state == ST_IDLE) || stop_end;
  assign take     = can_load && word_avail;

`ifdef UART_TX_FIFO_EN
  logic fifo_full;
  logic fifo_empty;

  uart_tx_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock(i_clock),
    .reset(i_reset),
    .push (i_valid && !fifo_full),
    .wdata(i_data),
    .pop  (take),
    .rdata(word),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign word_avail = !fifo_empty;
  assign queued     = !fifo_empty;
  assign o_ready    = !fifo_full;
`else
  assign word_avail = i_valid;
  assign word       = i_data;
  assign queued     = 1'b0;
  assign o_ready    = can_load;
`endif

  assign o_signal = line;
  assign o_busy   = (state != ST_IDLE) || queued;

  // Bit-period counter: runs while a frame is in flight, wraps every bit.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      bit_cnt <= '0;
    end else if (take || state == ST_IDLE || bit_end) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Serializer FSM, shift register and registered line output.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      bit_idx <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      line    <= 1'b1;
    end else if (take) begin
      state   <= ST_START;
      bit_idx <= '0;
      shift   <= word;
      par_bit <= (PARITY == PARITY_ODD) ? ~^word : ^word;
      line    <= 1'b0;
    end else begin
      case (state)
        ST_START: begin
          if (bit_end) begin
            state <= ST_DATA;
            line  <= shift[0];
            shift <= shift >> 1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              if (PARITY != PARITY_NONE) begin
                state <= ST_PARITY;
                line  <= par_bit;
              end else begin
                state <= ST_STOP;
                line  <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              line    <= shift[0];
              shift   <= shift >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state <= ST_STOP;
            line  <= 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (bit_idx == STOP_LAST) begin
              state   <= ST_IDLE;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          line  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg at DIVIDER = 10 (HZ=1000, BAUDRATE=100).
// Four instances cover 8N1, 8E1, 8O1 and 7E2; the FIFO scenario runs when
// UART_TX_FIFO_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx_cfg;

  localparam int DIV = 10;
`ifdef UART_TX_FIFO_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] valid;
  logic [8:0] data [4];
  logic [3:0] ready;
  logic [3:0] sig;
  logic [3:0] busy;
  logic [7:0] words [6];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.HZ(1000), .BAUDRATE(100), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .FIFO_DEPTH(4)) d0 (
    .i_clock(clk), .i_reset(rst), .i_data(data[0][7:0]), .i_valid(valid[0]),
    .o_ready(ready[0]), .o_signal(sig[0]), .o_busy(busy[0]));

  uart_tx_cfg #(.HZ(1000), .BAUDRATE(100), .DATA_BITS(8), .PARITY(1),
                .STOP_BITS(1), .FIFO_DEPTH(4)) d1 (
    .i_clock(clk), .i_reset(rst), .i_data(data[1][7:0]), .i_valid(valid[1]),
    .o_ready(ready[1]), .o_signal(sig[1]), .o_busy(busy[1]));

  uart_tx_cfg #(.HZ(1000), .BAUDRATE(100), .DATA_BITS(8), .PARITY(2),
                .STOP_BITS(1), .FIFO_DEPTH(4)) d2 (
    .i_clock(clk), .i_reset(rst), .i_data(data[2][7:0]), .i_valid(valid[2]),
    .o_ready(ready[2]), .o_signal(sig[2]), .o_busy(busy[2]));

  uart_tx_cfg #(.HZ(1000), .BAUDRATE(100), .DATA_BITS(7), .PARITY(1),
                .STOP_BITS(2), .FIFO_DEPTH(4)) d3 (
    .i_clock(clk), .i_reset(rst), .i_data(data[3][6:0]), .i_valid(valid[3]),
    .o_ready(ready[3]), .o_signal(sig[3]), .o_busy(busy[3]));

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Send one word on instance idx and compare every cycle of the frame
  // against the hand-built line pattern (bit j of frame = j-th line bit).
  task automatic send_frame(input int idx, input logic [8:0] word,
                            input logic [15:0] frame, input int nbits,
                            input string tag);
    logic got;
    logic rdy_exp;
    int   busy_low = 0;
    int   rdy_bad  = 0;
    int   pre_bad  = 0;
    @(negedge clk);
    check({tag, " ready before send"}, ready[idx], 1);
    data[idx]  = word;
    valid[idx] = 1'b1;
    @(posedge clk);
    #1 valid[idx] = 1'b0;
    for (int c = 0; c < LAT; c++) begin
      @(negedge clk);
      if (sig[idx] !== 1'b1) pre_bad++;
    end
    for (int j = 0; j < nbits; j++) begin
      got = frame[j];
      for (int c = 0; c < DIV; c++) begin
        @(negedge clk);
        if (sig[idx] !== frame[j]) got = sig[idx];
        if (busy[idx] !== 1'b1) busy_low++;
        rdy_exp = (LAT != 0) ? 1'b1 : ((j == nbits - 1) && (c == DIV - 1));
        if (ready[idx] !== rdy_exp) rdy_bad++;
      end
      check($sformatf("%s bit%0d", tag, j), got, frame[j]);
    end
    check({tag, " line idle before start"}, pre_bad, 0);
    check({tag, " busy during frame"}, busy_low, 0);
    check({tag, " ready during frame"}, rdy_bad, 0);
    @(negedge clk);
    check({tag, " line after frame"}, sig[idx], 1);
    check({tag, " busy after frame"}, busy[idx], 0);
  endtask

  // Stream words[0..nw-1] into d0 with valid held high, honouring ready, and
  // check the 8N1 line pattern of every frame back to back.
  task automatic stream(input int nw, input string tag, output int first_block);
    int   nacc = 0;
    bit   pend;
    int   busy_low = 0;
    int   pre_bad  = 0;
    int   cyc, bitn, f, pos;
    logic exp, got;
    first_block = -1;
    got = 1'b0;
    @(negedge clk);
    check({tag, " ready before send"}, ready[0], 1);
    data[0]  = {1'b0, words[0]};
    valid[0] = 1'b1;
    pend     = ready[0];
    for (int t = 0; t < LAT + nw * 10 * DIV; t++) begin
      @(negedge clk);
      if (pend) begin
        nacc++;
        if (nacc < nw) data[0] = {1'b0, words[nacc]};
        else valid[0] = 1'b0;
      end
      pend = valid[0] && ready[0];
      if (valid[0] && !ready[0] && first_block < 0) first_block = nacc;
      if (t < LAT) begin
        if (sig[0] !== 1'b1) pre_bad++;
      end else begin
        cyc  = t - LAT;
        bitn = cyc / DIV;
        f    = bitn / 10;
        pos  = bitn % 10;
        if (pos == 0) exp = 1'b0;
        else if (pos == 9) exp = 1'b1;
        else exp = words[f][pos-1];
        if (cyc % DIV == 0) got = exp;
        if (sig[0] !== exp) got = sig[0];
        if (busy[0] !== 1'b1) busy_low++;
        if (cyc % DIV == DIV - 1)
          check($sformatf("%s frame%0d bit%0d", tag, f, pos), got, exp);
      end
    end
    check({tag, " words accepted"}, nacc, nw);
    check({tag, " line idle before start"}, pre_bad, 0);
    check({tag, " busy through frames"}, busy_low, 0);
    @(negedge clk);
    check({tag, " line after frames"}, sig[0], 1);
    check({tag, " busy after frames"}, busy[0], 0);
  endtask

  initial begin
    int blk;
    int bad;
    rst   = 1'b1;
    valid = '0;
    for (int i = 0; i < 4; i++) data[i] = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset o_signal", sig[0], 1);
    check("reset o_busy", busy[0], 0);
    check("reset o_ready", ready[0], 1);
    check("reset all lines", sig, 4'hF);
    @(posedge clk);
    #1 rst = 1'b0;

    // Frame formats.
    send_frame(0, 9'h05A, {1'b1, 8'h5A, 1'b0}, 10, "8N1 5A");
    send_frame(1, 9'h05A, {1'b1, 1'b0, 8'h5A, 1'b0}, 11, "8E1 5A");
    send_frame(2, 9'h05A, {1'b1, 1'b1, 8'h5A, 1'b0}, 11, "8O1 5A");
    send_frame(3, 9'h07F, {2'b11, 1'b1, 7'h7F, 1'b0}, 11, "7E2 7F");

    // Back-to-back with valid held high.
    words[0] = 8'h01;
    words[1] = 8'h80;
    stream(2, "b2b", blk);

`ifdef UART_TX_FIFO_EN
    // Six-word burst into a 4-deep FIFO.
    words[0] = 8'hA1; words[1] = 8'h3C; words[2] = 8'h0F;
    words[3] = 8'hF0; words[4] = 8'h96; words[5] = 8'h55;
    stream(6, "fifo", blk);
    check("fifo ready drop after word", blk, 5);
`endif

    // Reset in the middle of data bit 3 of 0xA5.
    @(negedge clk);
    data[0]  = 9'h0A5;
    valid[0] = 1'b1;
    @(posedge clk);
    #1 valid[0] = 1'b0;
`ifdef UART_TX_FIFO_EN
    @(negedge clk);
    data[0]  = 9'h03C;
    valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (LAT + 44) @(negedge clk);
`else
    repeat (LAT + 46) @(negedge clk);
`endif
    check("pre-reset data bit3", sig[0], 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post-reset o_signal", sig[0], 1);
    check("post-reset o_busy", busy[0], 0);
    check("post-reset o_ready", ready[0], 1);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (sig[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
    end
    check("no frame resumes after reset", bad, 0);
    send_frame(0, 9'h0C3, {1'b1, 8'hC3, 1'b0}, 10, "post-reset C3");

    // Idle hold.
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (sig[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
    end
    check("idle hold 500 cycles", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
